// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer: streams a block of BRAM result words to uart_tx, clamped to a pixel byte or as raw LSB-first bytes
module uart_frame_streamer #(
  parameter int DATA_W = 23,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_frame_len,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_busy,
  output logic              o_send,
  output logic [7:0]        o_transmit_data,
  output logic              o_active,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_words_sent
);
  localparam int BYTES = (DATA_W + 7) / 8;
  localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [1:0] CNT_END = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  localparam logic signed [DATA_W-1:0] MAX_PIX = 255;
  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, LOAD, TX_REQ, TX_ACK, TX_DRAIN, DONE} state_t;
  state_t r_state, w_state;
  logic                     r_mode, w_mode;
  logic [ADDR_W-1:0]        r_base, w_base;
  logic [ADDR_W-1:0]        r_len, w_len;
  logic signed [DATA_W-1:0] r_word, w_word;
  logic [IDX_W-1:0]         r_idx, w_idx;
  logic [1:0]               r_cnt, w_cnt;
  logic [ADDR_W-1:0]        r_ws, w_ws;
  logic [ADDR_W-1:0]        r_rd_addr, w_rd_addr;
  logic [7:0]               r_tx_data, w_tx_data;
  logic                     r_active, w_active;
  logic                     r_done, w_done;
  logic [8*BYTES-1:0]       w_ext;
  logic [7:0]               w_clamp;
  logic [7:0]               w_sel;
  // Sign-extend to a whole number of bytes so the top raw byte carries the sign
  assign w_ext = {{(8*BYTES-DATA_W+1){r_word[DATA_W-1]}}, r_word[DATA_W-2:0]};
  assign w_clamp = r_word[DATA_W-1] ? 8'h00 : (r_word > MAX_PIX ? 8'hFF : r_word[7:0]);
  assign w_sel = r_mode ? w_ext[8*r_idx +: 8] : w_clamp;
  assign o_rd_addr = r_rd_addr;
  assign o_transmit_data = o_send ? w_sel : r_tx_data;
  assign o_active = r_active;
  assign o_done = r_done;
  assign o_words_sent = r_ws;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_base    <= '0;
      r_len     <= '0;
      r_word    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_ws      <= '0;
      r_rd_addr <= '0;
      r_tx_data <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mode    <= w_mode;
      r_base    <= w_base;
      r_len     <= w_len;
      r_word    <= w_word;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_ws      <= w_ws;
      r_rd_addr <= w_rd_addr;
      r_tx_data <= w_tx_data;
      r_active  <= w_active;
      r_done    <= w_done;
    end
  end
  always_comb begin
    w_state   = r_state;
    w_mode    = r_mode;
    w_base    = r_base;
    w_len     = r_len;
    w_word    = r_word;
    w_idx     = r_idx;
    w_cnt     = r_cnt;
    w_ws      = r_ws;
    w_tx_data = r_tx_data;
    w_active  = r_active;
    w_done    = r_done;
    o_send    = 1'b0;
    case (r_state)
      IDLE, DONE: if (i_start) begin
        w_mode   = i_mode;
        w_base   = i_base_addr;
        w_len    = i_frame_len;
        w_ws     = '0;
        w_done   = i_frame_len == '0;
        w_active = i_frame_len != '0;
        w_state  = i_frame_len == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        w_cnt   = '0;
        w_state = RD_LAT == 1 ? LOAD : RD_WAIT;
      end
      RD_WAIT: begin
        w_cnt   = r_cnt + 2'd1;
        w_state = r_cnt == CNT_END ? LOAD : RD_WAIT;
      end
      LOAD: begin
        w_word  = i_rd_data;
        w_idx   = '0;
        w_state = TX_REQ;
      end
      TX_REQ: if (!i_busy) begin
        o_send    = 1'b1;
        w_tx_data = w_sel;
        w_state   = TX_ACK;
      end
      TX_ACK: w_state = i_busy ? TX_DRAIN : TX_ACK;
      TX_DRAIN: if (!i_busy) begin
        if (r_mode && r_idx != LAST_IDX) begin
          w_idx   = r_idx + 1'b1;
          w_state = TX_REQ;
        end else begin
          w_ws     = r_ws + 1'b1;
          w_done   = w_ws == r_len;
          w_active = w_ws != r_len;
          w_state  = w_ws == r_len ? DONE : ISSUE;
        end
      end
      default: w_state = IDLE;
    endcase
    // Address is registered on entry to ISSUE so BRAM latency counts from the ISSUE cycle
    w_rd_addr = w_state == ISSUE ? w_base + w_ws : r_rd_addr;
  end
endmodule

// File: tb/tb_uart_frame_streamer.sv
// tb_uart_frame_streamer: randomized scoreboard bench with BRAM and uart_tx models around uart_frame_streamer
module tb_uart_frame_streamer;
  localparam int DW = 23;
  localparam int AW = 16;
  localparam int RL = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic busy;
  logic send;
  logic [7:0] tx;
  logic active;
  logic done;
  logic [AW-1:0] ws;
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] pipe [0:RL-1];
  logic [7:0] exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic [7:0] tx_lat;
  logic prev_send = 1'b0;
  int hold = 1;
  int bcnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_frame_streamer #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_mode(mode), .i_base_addr(base),
    .i_frame_len(len), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .i_busy(busy),
    .o_send(send), .o_transmit_data(tx), .o_active(active), .o_done(done), .o_words_sent(ws));
  always @(posedge clk) begin
    pipe[0] <= mem[rd_addr];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign rd_data = pipe[RL-1];
  always @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (send) begin
      busy <= 1'b1;
      bcnt <= hold;
      tx_lat <= tx;
    end else if (busy) begin
      if (bcnt <= 1) busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (send) begin
      chk("send_while_busy", 32'(busy), 32'd0);
      chk("send_back_to_back", 32'(prev_send), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_send", 32'd1, 32'd0);
      else begin
        chk("tx_byte", 32'(tx), 32'(exp_q.pop_front()));
        chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
    end
    if (busy && active) chk("tx_stable", 32'(tx), 32'(tx_lat));
    prev_send = send;
  end
  task automatic push_frame(input bit m, input logic [AW-1:0] b, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    logic signed [DW-1:0] s;
    int v;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      s = mem[a];
      v = s;
      if (!m) begin
        exp_q.push_back(8'(v < 0 ? 0 : (v > 255 ? 255 : v)));
        addr_q.push_back(a);
      end else begin
        for (int k = 0; k < (DW + 7) / 8; k++) begin
          exp_q.push_back(8'((v >>> (8 * k)) & 255));
          addr_q.push_back(a);
        end
      end
    end
  endtask
  task automatic start_frame(input bit m, input logic [AW-1:0] b, input logic [AW-1:0] l, input int h);
    hold = h;
    push_frame(m, b, l);
    @(posedge clk); #1;
    start = 1'b1; mode = m; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); base = AW'($urandom); len = AW'($urandom);
    @(negedge clk);
    chk("active_after_start", 32'(active), 32'(l != 0));
    chk("done_after_start", 32'(done), 32'(l == 0));
    chk("ws_after_start", 32'(ws), 32'd0);
  endtask
  task automatic wait_done(input logic [AW-1:0] l);
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    chk("done_timeout", 32'(done), 32'd1);
    chk("words_sent", 32'(ws), 32'(l));
    chk("active_in_done", 32'(active), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_tx", 32'(tx), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom % 2) ? DW'($urandom) : DW'($urandom_range(0, 800) - 400);
    mem[0] = DW'(-5); mem[1] = DW'(0); mem[2] = DW'(128); mem[3] = DW'(300);
    mem[10] = DW'(-2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1 reset = 1'b0;
    start_frame(1'b0, 16'd0, 16'd4, 2);
    wait_done(16'd4);
    start_frame(1'b1, 16'd10, 16'd1, 1);
    wait_done(16'd1);
    start_frame(1'b1, 16'hFFFE, 16'd3, 3);
    wait_done(16'd3);
    start_frame(1'b0, 16'hFFFE, 16'd3, 1);
    wait_done(16'd3);
    start_frame(1'b0, 16'd50, 16'd0, 1);
    chk("len0_ws", 32'(ws), 32'd0);
    repeat (5) @(negedge clk);
    chk("len0_done_hold", 32'(done), 32'd1);
    start_frame(1'b1, 16'd20, 16'd2, 50);
    repeat (120) @(posedge clk);
    #1 start = 1'b1; mode = 1'b0; base = 16'd300; len = 16'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_done(16'd2);
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] l;
      l = AW'($urandom_range(1, 6));
      start_frame(1'($urandom), AW'($urandom), l, int'($urandom_range(1, 4)));
      wait_done(l);
    end
    start_frame(1'b0, 16'd100, 16'd5, 2);
    for (int i = 0; i < 5000 && ws != 16'd2; i++) @(negedge clk);
    chk("reached_ws2", 32'(ws), 32'd2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_reset_ws", 32'(ws), 32'd0);
    start_frame(1'b1, AW'($urandom), 16'd2, 1);
    wait_done(16'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
